// File: rtl/bp_pkg.sv
// Shared encodings, entry field layout and counter init values for the
// set-associative branch predictor.
package bp_pkg;

  localparam logic [1:0] CORR_NONE = 2'b00;
  localparam logic [1:0] CORR_CNI  = 2'b10;
  localparam logic [1:0] CORR_PBT  = 2'b11;

  // Entry layout, LSB first: {valid, tag, target, ctr}
  function automatic int target_lsb(input int ctr_w);
    return ctr_w;
  endfunction

  function automatic int tag_lsb(input int pc_w, input int ctr_w);
    return ctr_w + pc_w;
  endfunction

  function automatic int valid_bit(input int pc_w, input int set_w, input int ctr_w);
    return ctr_w + pc_w + (pc_w - set_w);
  endfunction

  function automatic int entry_w(input int pc_w, input int set_w, input int ctr_w);
    return valid_bit(pc_w, set_w, ctr_w) + 1;
  endfunction

  // Conditional branches start weakly not-taken; jumps start saturated taken.
  function automatic int ctr_init_btype(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  function automatic int ctr_init_jump(input int ctr_w);
    return (1 << ctr_w) - 1;
  endfunction

endpackage

// File: rtl/bp_set_lookup.sv
// Tag match across the ways of one set; the lowest matching way is selected.
module bp_set_lookup
  import bp_pkg::*;
#(
  parameter  int PC_W  = 10,
  parameter  int SET_W = 4,
  parameter  int WAYS  = 4,
  parameter  int CTR_W = 2,
  localparam int TAG_W = PC_W - SET_W,
  localparam int EW    = entry_w(PC_W, SET_W, CTR_W),
  localparam int IDX_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][EW-1:0] entries,
  input  logic [TAG_W-1:0]        tag,
  output logic                    hit,
  output logic [WAYS-1:0]         way_onehot,
  output logic [IDX_W-1:0]        way_idx,
  output logic [EW-1:0]           entry
);

  localparam int TAG_LSB   = tag_lsb(PC_W, CTR_W);
  localparam int VALID_BIT = valid_bit(PC_W, SET_W, CTR_W);

  logic [WAYS-1:0] match;

  always_comb begin
    for (int w = 0; w < WAYS; w++)
      match[w] = entries[w][VALID_BIT] && (entries[w][TAG_LSB +: TAG_W] == tag);
  end

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    hit        = 1'b0;
    way_onehot = '0;
    way_idx    = '0;
    entry      = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        hit           = 1'b1;
        way_onehot    = '0;
        way_onehot[w] = 1'b1;
        way_idx       = IDX_W'(w);
        entry         = entries[w];
      end
    end
  end

endmodule

// File: rtl/assoc_branch_predictor.sv
// N-way set-associative branch history table: combinational IF lookup,
// ID allocation with per-set FIFO replacement, EXE counter update and correction.
module assoc_branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int SET_W = 4,
  parameter int WAYS  = 4,
  parameter int CTR_W = 2
) (
  input  logic            CLK,
  input  logic            nrst,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_prediction,
  output logic [PC_W-1:0] if_pbt,
  input  logic [PC_W-1:0] id_pc,
  input  logic [PC_W-1:0] id_target,
  input  logic            id_is_btype,
  input  logic            id_is_jump,
  input  logic [PC_W-1:0] exe_pc,
  input  logic            exe_is_btype,
  input  logic            exe_taken,
  input  logic            exe_predicted,
  input  logic [PC_W-1:0] exe_target,
  output logic [1:0]      exe_correction,
  output logic [PC_W-1:0] exe_pbt,
  output logic [PC_W-1:0] exe_cni,
  output logic            flush
);

  localparam int TAG_W      = PC_W - SET_W;
  localparam int NSETS      = 1 << SET_W;
  localparam int IDX_W      = $clog2(WAYS);
  localparam int EW         = entry_w(PC_W, SET_W, CTR_W);
  localparam int DW         = EW - 1;
  localparam int TARGET_LSB = target_lsb(CTR_W);

  localparam logic [CTR_W-1:0] CTR_BTYPE = CTR_W'(ctr_init_btype(CTR_W));
  localparam logic [CTR_W-1:0] CTR_JUMP  = CTR_W'(ctr_init_jump(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX   = '1;

  logic [NSETS-1:0][WAYS-1:0]  valid_q;
  logic [NSETS-1:0][IDX_W-1:0] fifo_ptr_q;
  logic [DW-1:0]               data_q [NSETS][WAYS];  // {tag, target, ctr}

  logic [SET_W-1:0] if_set, id_set, exe_set;
  logic [TAG_W-1:0] if_tag, id_tag, exe_tag;

  assign if_set  = if_pc[SET_W-1:0];
  assign if_tag  = if_pc[PC_W-1:SET_W];
  assign id_set  = id_pc[SET_W-1:0];
  assign id_tag  = id_pc[PC_W-1:SET_W];
  assign exe_set = exe_pc[SET_W-1:0];
  assign exe_tag = exe_pc[PC_W-1:SET_W];

  logic [WAYS-1:0][EW-1:0] if_entries, id_entries, exe_entries;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      if_entries[w]  = {valid_q[if_set][w],  data_q[if_set][w]};
      id_entries[w]  = {valid_q[id_set][w],  data_q[id_set][w]};
      exe_entries[w] = {valid_q[exe_set][w], data_q[exe_set][w]};
    end
  end

  logic             if_hit, id_hit, exe_hit;
  logic [WAYS-1:0]  if_onehot, id_onehot, exe_onehot;
  logic [IDX_W-1:0] if_idx, id_idx, exe_idx;
  logic [EW-1:0]    if_entry, id_entry, exe_entry;

  bp_set_lookup #(.PC_W(PC_W), .SET_W(SET_W), .WAYS(WAYS), .CTR_W(CTR_W)) u_if_lookup (
    .entries(if_entries), .tag(if_tag), .hit(if_hit),
    .way_onehot(if_onehot), .way_idx(if_idx), .entry(if_entry)
  );

  bp_set_lookup #(.PC_W(PC_W), .SET_W(SET_W), .WAYS(WAYS), .CTR_W(CTR_W)) u_id_lookup (
    .entries(id_entries), .tag(id_tag), .hit(id_hit),
    .way_onehot(id_onehot), .way_idx(id_idx), .entry(id_entry)
  );

  bp_set_lookup #(.PC_W(PC_W), .SET_W(SET_W), .WAYS(WAYS), .CTR_W(CTR_W)) u_exe_lookup (
    .entries(exe_entries), .tag(exe_tag), .hit(exe_hit),
    .way_onehot(exe_onehot), .way_idx(exe_idx), .entry(exe_entry)
  );

  // Lookup fields that no consumer in this block needs.
  logic unused_lookup;
  assign unused_lookup = ^{if_onehot, if_idx, if_entry, id_onehot, id_idx, id_entry};

  assign if_prediction = if_hit & if_entry[CTR_W-1];
  assign if_pbt        = if_hit ? if_entry[TARGET_LSB +: PC_W] : '0;

  logic mispredict;
  assign mispredict     = exe_is_btype & (exe_predicted ^ exe_taken);
  assign flush          = mispredict;
  assign exe_correction = !mispredict ? CORR_NONE : (exe_taken ? CORR_PBT : CORR_CNI);
  assign exe_pbt        = exe_target;
  assign exe_cni        = exe_pc + PC_W'(1);

  logic [CTR_W-1:0] exe_ctr, ctr_next, alloc_ctr;
  assign exe_ctr = exe_entry[CTR_W-1:0];

  always_comb begin
    ctr_next = exe_ctr;
    if (exe_taken) begin
      if (exe_ctr != CTR_MAX) ctr_next = exe_ctr + CTR_W'(1);
    end else if (exe_ctr != '0) begin
      ctr_next = exe_ctr - CTR_W'(1);
    end
  end

  logic             alloc, upd, upd_conflict;
  logic [IDX_W-1:0] alloc_way;

  assign alloc        = (id_is_btype | id_is_jump) & ~id_hit & ~flush;
  assign alloc_way    = fifo_ptr_q[id_set];
  assign alloc_ctr    = id_is_jump ? CTR_JUMP : CTR_BTYPE;
  // An allocation landing on the entry being updated replaces it outright.
  assign upd_conflict = alloc && (id_set == exe_set) && (alloc_way == exe_idx);
  assign upd          = exe_is_btype & exe_hit & ~upd_conflict;

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      valid_q    <= '0;
      fifo_ptr_q <= '0;
    end else if (alloc) begin
      // NOTE: sequential state always uses non-blocking assignment.
      valid_q[id_set][alloc_way] <= 1'b1;
      fifo_ptr_q[id_set]         <= alloc_way + IDX_W'(1);
    end
  end

  // NOTE: the payload array has no reset; cleared valid bits make it unobservable.
  always_ff @(posedge CLK) begin
    for (int w = 0; w < WAYS; w++)
      if (upd && exe_onehot[w]) data_q[exe_set][w][CTR_W-1:0] <= ctr_next;
    if (alloc) data_q[id_set][alloc_way] <= {id_tag, id_target, alloc_ctr};
  end

endmodule

// File: tb/tb_assoc_branch_predictor.sv
// Directed bench for assoc_branch_predictor with hand-computed expectations.
module tb_assoc_branch_predictor;

  localparam int PC_W  = 10;
  localparam int SET_W = 4;
  localparam int WAYS  = 4;
  localparam int CTR_W = 2;

  logic            CLK = 1'b0;
  logic            nrst;
  logic [PC_W-1:0] if_pc;
  logic            if_prediction;
  logic [PC_W-1:0] if_pbt;
  logic [PC_W-1:0] id_pc, id_target;
  logic            id_is_btype, id_is_jump;
  logic [PC_W-1:0] exe_pc, exe_target;
  logic            exe_is_btype, exe_taken, exe_predicted;
  logic [1:0]      exe_correction;
  logic [PC_W-1:0] exe_pbt, exe_cni;
  logic            flush;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assoc_branch_predictor #(.PC_W(PC_W), .SET_W(SET_W), .WAYS(WAYS), .CTR_W(CTR_W)) dut (
    .CLK(CLK), .nrst(nrst),
    .if_pc(if_pc), .if_prediction(if_prediction), .if_pbt(if_pbt),
    .id_pc(id_pc), .id_target(id_target), .id_is_btype(id_is_btype), .id_is_jump(id_is_jump),
    .exe_pc(exe_pc), .exe_is_btype(exe_is_btype), .exe_taken(exe_taken),
    .exe_predicted(exe_predicted), .exe_target(exe_target),
    .exe_correction(exe_correction), .exe_pbt(exe_pbt), .exe_cni(exe_cni), .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    id_is_btype   = 1'b0;
    id_is_jump    = 1'b0;
    exe_is_btype  = 1'b0;
    exe_taken     = 1'b0;
    exe_predicted = 1'b0;
  endtask

  task automatic look(input string tag, input logic [PC_W-1:0] pc,
                      input logic pred, input logic [PC_W-1:0] pbt);
    if_pc = pc;
    #1;
    check({tag, " pred"}, 32'(if_prediction), 32'(pred));
    check({tag, " pbt"},  32'(if_pbt),        32'(pbt));
  endtask

  task automatic alloc(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] target, input logic jump);
    id_pc       = pc;
    id_target   = target;
    id_is_btype = !jump;
    id_is_jump  = jump;
    step();
    idle();
  endtask

  task automatic resolve(input logic [PC_W-1:0] pc, input logic taken);
    exe_pc        = pc;
    exe_target    = '0;
    exe_is_btype  = 1'b1;
    exe_taken     = taken;
    exe_predicted = taken;
    step();
    idle();
  endtask

  initial begin
    idle();
    nrst = 1'b0;
    if_pc = '0; id_pc = '0; id_target = '0; exe_pc = '0; exe_target = '0;
    repeat (2) @(posedge CLK);
    #1;
    look("in reset 0x044", 10'h044, 1'b0, 10'h000);
    nrst = 1'b1;
    #1;
    look("after reset 0x044", 10'h044, 1'b0, 10'h000);

    exe_pc = 10'h3FF; exe_target = 10'h155;
    #1;
    check("idle corr", 32'(exe_correction), 32'h0);
    check("idle flush", 32'(flush), 32'h0);
    check("cni wrap", 32'(exe_cni), 32'h000);
    check("pbt passthrough", 32'(exe_pbt), 32'h155);

    // B-type allocate, then taken mispredict squashes a concurrent ID allocation.
    alloc(10'h044, 10'h080, 1'b0);
    look("btype 0x044", 10'h044, 1'b0, 10'h080);
    exe_pc = 10'h044; exe_target = 10'h080;
    exe_is_btype = 1'b1; exe_taken = 1'b1; exe_predicted = 1'b0;
    id_pc = 10'h055; id_target = 10'h0AA; id_is_btype = 1'b1;
    #1;
    check("taken mispredict corr", 32'(exe_correction), 32'h3);
    check("taken mispredict flush", 32'(flush), 32'h1);
    check("taken mispredict pbt", 32'(exe_pbt), 32'h080);
    check("taken mispredict cni", 32'(exe_cni), 32'h045);
    step();
    idle();
    look("0x044 after taken", 10'h044, 1'b1, 10'h080);
    look("flushed alloc 0x055", 10'h055, 1'b0, 10'h000);

    // Not-taken mispredict on an EXE miss: correction only, no table change.
    exe_pc = 10'h200; exe_target = 10'h300;
    exe_is_btype = 1'b1; exe_taken = 1'b0; exe_predicted = 1'b1;
    #1;
    check("nt mispredict corr", 32'(exe_correction), 32'h2);
    check("nt mispredict flush", 32'(flush), 32'h1);
    check("nt mispredict cni", 32'(exe_cni), 32'h201);
    exe_predicted = 1'b0;
    #1;
    check("correct predict corr", 32'(exe_correction), 32'h0);
    check("correct predict flush", 32'(flush), 32'h0);
    step();
    idle();
    look("0x044 after exe miss", 10'h044, 1'b1, 10'h080);

    // Jump: saturated counter, untouched by non-B-type EXE traffic.
    alloc(10'h013, 10'h100, 1'b1);
    look("jump 0x013", 10'h013, 1'b1, 10'h100);
    exe_pc = 10'h013; exe_target = 10'h100; exe_taken = 1'b0; exe_predicted = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("jump exe corr", 32'(exe_correction), 32'h0);
      check("jump exe flush", 32'(flush), 32'h0);
      step();
    end
    idle();
    look("jump ctr held", 10'h013, 1'b1, 10'h100);

    nrst = 1'b0;
    #1;
    look("reset clears 0x013", 10'h013, 1'b0, 10'h000);
    step();
    nrst = 1'b1;
    #1;

    // Five branches in set 4: FIFO evicts the first.
    for (int i = 0; i < 5; i++)
      alloc(PC_W'(10'h004 + 16 * i), PC_W'(10'h104 + 16 * i), 1'b0);
    look("evicted 0x004", 10'h004, 1'b0, 10'h000);
    for (int i = 1; i < 5; i++)
      look("set4 resident", PC_W'(10'h004 + 16 * i), 1'b0, PC_W'(10'h104 + 16 * i));

    // Ways 1..3 refill; pointer returns to way 0 which holds 0x044.
    alloc(10'h054, 10'h154, 1'b0);
    alloc(10'h064, 10'h164, 1'b0);
    alloc(10'h074, 10'h174, 1'b0);

    // Same set, same way: allocation wins, counter update dropped.
    id_pc = 10'h084; id_target = 10'h184; id_is_btype = 1'b1;
    exe_pc = 10'h044; exe_is_btype = 1'b1; exe_taken = 1'b1; exe_predicted = 1'b1;
    #1;
    check("conflict no flush", 32'(flush), 32'h0);
    step();
    idle();
    look("conflict new entry", 10'h084, 1'b0, 10'h184);
    look("conflict old gone", 10'h044, 1'b0, 10'h000);
    resolve(10'h084, 1'b1);
    look("0x084 init was 01", 10'h084, 1'b1, 10'h184);

    // Same set, different ways: both writes commit.
    id_pc = 10'h094; id_target = 10'h194; id_is_btype = 1'b1;
    exe_pc = 10'h064; exe_is_btype = 1'b1; exe_taken = 1'b1; exe_predicted = 1'b1;
    step();
    idle();
    look("diff way alloc", 10'h094, 1'b0, 10'h194);
    look("diff way update", 10'h064, 1'b1, 10'h164);
    look("diff way evicted", 10'h054, 1'b0, 10'h000);

    // Saturation at both ends on 0x084 (currently 10).
    resolve(10'h084, 1'b1);
    resolve(10'h084, 1'b1);
    look("sat high", 10'h084, 1'b1, 10'h184);
    resolve(10'h084, 1'b0);
    look("11 to 10", 10'h084, 1'b1, 10'h184);
    resolve(10'h084, 1'b0);
    resolve(10'h084, 1'b0);
    resolve(10'h084, 1'b0);
    look("sat low", 10'h084, 1'b0, 10'h184);
    resolve(10'h084, 1'b1);
    resolve(10'h084, 1'b1);
    look("00 up to 10", 10'h084, 1'b1, 10'h184);

    // Asynchronous reset mid-cycle after ten allocations, with ID allocate pending.
    if_pc = 10'h094;
    id_pc = 10'h0A4; id_target = 10'h1A4; id_is_btype = 1'b1;
    #2;
    nrst = 1'b0;
    #1;
    check("async reset pred", 32'(if_prediction), 32'h0);
    check("async reset pbt", 32'(if_pbt), 32'h0);
    step();
    idle();
    nrst = 1'b1;
    #1;
    look("no write in reset", 10'h0A4, 1'b0, 10'h000);
    look("reset miss 0x094", 10'h094, 1'b0, 10'h000);
    look("reset miss 0x084", 10'h084, 1'b0, 10'h000);

    alloc(10'h0B4, 10'h1B4, 1'b0);
    look("post-reset alloc", 10'h0B4, 1'b0, 10'h1B4);
    alloc(10'h0C4, 10'h1C4, 1'b0);
    alloc(10'h0D4, 10'h1D4, 1'b0);
    alloc(10'h0E4, 10'h1E4, 1'b0);
    alloc(10'h0F4, 10'h1F4, 1'b0);
    look("post-reset evict 0x0B4", 10'h0B4, 1'b0, 10'h000);
    look("post-reset 0x0C4", 10'h0C4, 1'b0, 10'h1C4);
    look("post-reset 0x0F4", 10'h0F4, 1'b0, 10'h1F4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_branch_predictor.md
# assoc_branch_predictor

Parametrised N-way set-associative branch history table with saturating-counter direction prediction and per-set FIFO replacement. It replaces the fixed 64-entry predictor in the fetch path. It answers IF-stage lookups combinationally, allocates entries for branches and jumps decoded in ID, and resolves B-type outcomes in EXE. Resolution produces a PC correction, a flush, and an in-place counter update.

## Interface
Parameters:
- PC_W, 10, width of stored PC / target (word address, byte PC[PC_W+1:2])
- SET_W, 4, log2 of set count; TAG_W = PC_W - SET_W
- WAYS, 4, associativity; power of two, 2..8
- CTR_W, 2, saturating counter width; prediction = counter MSB

Ports:
- CLK  in  1  clock; all writes on rising edge
- nrst  in  1  asynchronous, active-low reset
- if_pc  in  PC_W  fetch PC
- if_prediction  out  1  1 = predict taken
- if_pbt  out  PC_W  predicted branch target
- id_pc  in  PC_W  decode PC
- id_target  in  PC_W  decoded branch/jump target
- id_is_btype  in  1  decode holds conditional branch
- id_is_jump  in  1  decode holds JAL
- exe_pc  in  PC_W  execute PC
- exe_is_btype  in  1  execute holds conditional branch
- exe_taken  in  1  resolved branch outcome
- exe_predicted  in  1  if_prediction piped to EXE with the instruction
- exe_target  in  PC_W  computed branch target
- exe_correction  out  2  00 none, 10 select exe_cni, 11 select exe_pbt
- exe_pbt  out  PC_W  equals exe_target
- exe_cni  out  PC_W  exe_pc + 1, modulo 2^PC_W
- flush  out  1  mispredict; squash IF/ID

## Operation
- Entry: {valid, tag[TAG_W], target[PC_W], ctr[CTR_W]}. Storage is 2^SET_W × WAYS entries. Each set has a FIFO pointer (log2 WAYS bits).
- Set = pc[SET_W-1:0]; tag = pc[PC_W-1:SET_W].
- Hit: valid && tag match. Multiple hits are impossible by construction; if one occurs, the lowest way wins.
- IF, combinational:
  - On hit: if_prediction = ctr MSB; if_pbt = target.
  - On miss: if_prediction = 0 and if_pbt = 0.
- ID allocate, when (id_is_btype | id_is_jump) && no hit in the ID set && !flush:
  - Write way fifo_ptr[set] with valid = 1, the ID tag, and id_target.
  - Initial ctr: B-type = 01…1 (weakly not-taken, MSB 0, rest ones? no: value 2^(CTR_W-1)-1); jump = all ones.
  - fifo_ptr[set] increments, wrapping at WAYS.
  - An ID hit performs no write.
- EXE resolve, when exe_is_btype:
  - mispredict = exe_predicted != exe_taken.
  - exe_correction: 00 if no mispredict; 11 if exe_taken; 10 otherwise.
  - flush = mispredict. When exe_is_btype = 0, exe_correction = 00 and flush = 0.
  - On an EXE hit, ctr saturating-increments if taken and decrements if not taken (holds at all ones / zero). The write happens at the clock edge.
  - On an EXE miss, no table write.
- Jumps never update counters.
- Simultaneous ID allocate and EXE update to the same set and way: the allocation wins and the counter update is dropped. Different ways: both writes commit.
- Same-cycle read-after-write is not forwarded. Lookups see the pre-edge table.

## Timing
- IF, ID-hit and EXE outputs are purely combinational from the inputs and the current table state.
- Allocation and counter updates become visible to lookups one cycle after the edge.
- A branch allocated in ID at edge k hits in IF at cycle k+1.
- Reset (asynchronous, any cycle, including mid-update):
  - Clears every valid bit and every fifo_ptr to 0.
  - Tags, targets and counters are don't-care.
  - While nrst = 0: if_prediction = 0, if_pbt = 0, and no writes occur.
  - exe_correction, flush, exe_pbt and exe_cni follow their combinational definitions. The pipeline gates them during reset.
- Counter arithmetic is CTR_W bits with no wrap. fifo_ptr wraps modulo WAYS.

## Structure
- Package bp_pkg holds:
  - correction encodings CORR_NONE = 2'b00, CORR_CNI = 2'b10, CORR_PBT = 2'b11;
  - the entry field-offset functions of PC_W / SET_W / CTR_W;
  - the counter init helper functions.
- Sub-module bp_set_lookup handles one set of WAYS entries plus a tag. It outputs hit, one-hot way, way index and the selected entry. It is instantiated three times: IF, ID and EXE.
- The top level holds the storage array, the fifo_ptr array, the write arbitration and the correction logic.

## Test plan
- Reset, then if_pc = 0x044 → if_prediction = 0, if_pbt = 0.
- ID B-type at pc 0x044, target 0x080:
  - Next cycle, if_pc 0x044 → hit, pred 0, pbt 0x080.
  - Then EXE taken with exe_predicted 0 → correction 11, flush 1, exe_pbt 0x080.
  - Next lookup gives pred 1.
- ID jump at 0x013, target 0x100 → next-cycle IF pred 1, pbt 0x100. Counter stays all ones after 3 EXE not-taken cycles with exe_is_btype = 0.
- Five distinct branches in set 4 (pcs 0x004, 0x014, 0x024, 0x034, 0x044):
  - The fifth evicts 0x004 (IF miss).
  - 0x014 through 0x044 still hit.
- Same cycle: EXE not-taken update on way 0 of set 4 while ID allocates set 4 with fifo_ptr = 0 → the new entry is present with init counter, and the update is dropped.
- Assert nrst low mid-run after 10 allocations → all lookups miss, and fifo_ptr restarts at way 0 on the next allocation.
